force_cache_accumulator: RTL

Per-cell force cache: the receiving end of the force write-back path. It accepts force packets {particle_id, fz, fy, fx} from the force write-back arbitration unit, buffers them, and accumulates them into a per-particle force RAM using a read-modify-write pipeline with hazard forwarding. It serves motion-update reads with clear-on-read, so the next iteration starts at zero. One instance per cell.

---
 rtl/force_cache_accumulator.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/force_cache_accumulator.sv
// Per-cell force cache: buffers incoming force packets and accumulates
// them into a per-particle force RAM; motion-update reads clear on read.
module force_cache_accumulator #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int FORCE_CACHE_DEPTH = 100,
  parameter int FORCE_DATA_WIDTH  = 3*DATA_WIDTH+PARTICLE_ID_WIDTH,
  parameter int FORCE_CACHE_WIDTH = 3*DATA_WIDTH,
  parameter int IN_FIFO_DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FORCE_DATA_WIDTH-1:0]  force_and_addr_in,
  input  logic                         force_wr_enable,
  input  logic                         motion_update_rd_request,
  input  logic [PARTICLE_ID_WIDTH-1:0] motion_update_rd_addr,
  output logic                         all_force_input_buffer_empty,
  output logic [FORCE_CACHE_WIDTH-1:0] force_to_MU,
  output logic [PARTICLE_ID_WIDTH-1:0] force_id_to_MU,
  output logic                         force_valid_to_MU,
  output logic                         in_buffer_full,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(IN_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDW   = PARTICLE_ID_WIDTH;
  localparam int FCW   = FORCE_CACHE_WIDTH;
  localparam int DW    = DATA_WIDTH;

  localparam logic [IDW-1:0]   LAST_ID   = IDW'(FORCE_CACHE_DEPTH-1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(IN_FIFO_DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] init_addr_q;
  logic           run;

  logic [FORCE_DATA_WIDTH-1:0] fifo_mem [IN_FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q;
  logic [PTR_W-1:0]            rd_ptr_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic                        full_q;
  logic                        ovf_q;
  logic                        push;
  logic                        pop;

  logic [FORCE_DATA_WIDTH-1:0] pop_pkt;
  logic [IDW-1:0]              pop_id;
  logic [FCW-1:0]              pop_force;
  logic                        pop_ok;

  logic [FCW-1:0] force_ram [FORCE_CACHE_DEPTH];

  logic           r_valid_q;
  logic           r_valid_d;
  logic [IDW-1:0] r_addr_q;
  logic [FCW-1:0] r_force_q;

  logic           w_valid_q;
  logic           w_valid_d;
  logic [IDW-1:0] w_addr_q;
  logic [FCW-1:0] w_new_q;
  logic [FCW-1:0] ram_q;
  logic           fwd_q;
  logic [FCW-1:0] fwd_data_q;
  logic [FCW-1:0] w_old;
  logic [FCW-1:0] w_sum;

  logic           mu_valid_q;
  logic [IDW-1:0] mu_id_q;
  logic [FCW-1:0] mu_force_q;
  logic           mu_rd;
  logic           empty_q;

  assign run   = (state_q == ST_RUN);
  assign mu_rd = motion_update_rd_request && run;

  // Zero sweep of the RAM after reset, then run until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + IDW'(1);
          if (init_addr_q == LAST_ID) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: state_q <= ST_RUN;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // FIFO handshake; push judged on the registered full flag
  always_comb begin
    push      = force_wr_enable && !full_q;
    pop       = run && (cnt_q != '0) && !motion_update_rd_request;
    cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
    pop_pkt   = fifo_mem[rd_ptr_q];
    pop_id    = pop_pkt[FORCE_DATA_WIDTH-1 -: IDW];
    pop_force = pop_pkt[FCW-1:0];
    pop_ok    = pop && (pop_id <= LAST_ID);
    r_valid_d = pop_ok;
    w_valid_d = r_valid_q;
  end

  // FIFO pointers, occupancy, full and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == FIFO_FULL);
      ovf_q    <= ovf_q || (force_wr_enable && full_q);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= force_and_addr_in;
    end
  end

  // Pipeline valid bits and same-address forward select
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      fwd_q     <= 1'b0;
    end else begin
      r_valid_q <= r_valid_d;
      w_valid_q <= w_valid_d;
      fwd_q     <= r_valid_q && w_valid_q &&
                   (r_addr_q == w_addr_q);
    end
  end

  // Pipeline data: R reads the RAM, W gets the in-flight sum as bypass
  always_ff @(posedge clk) begin
    if (pop_ok) begin
      r_addr_q  <= pop_id;
      r_force_q <= pop_force;
    end
    w_addr_q   <= r_addr_q;
    w_new_q    <= r_force_q;
    ram_q      <= force_ram[r_addr_q];
    fwd_data_q <= w_sum;
  end

  // Per-component wrapping add of old entry and new packet
  always_comb begin
    w_sum = '0;
    w_old = fwd_q ? fwd_data_q : ram_q;
    for (int i = 0; i < 3; i++) begin
      w_sum[i*DW +: DW] = w_old[i*DW +: DW] + w_new_q[i*DW +: DW];
    end
  end

  // Single RAM write port: init sweep, clear-on-read, accumulate
  always_ff @(posedge clk) begin
    if (!run) begin
      force_ram[init_addr_q] <= '0;
    end else if (mu_valid_q) begin
      force_ram[mu_id_q] <= '0;
    end else if (w_valid_q) begin
      force_ram[w_addr_q] <= w_sum;
    end
  end

  // MU read response; back-to-back same-address read sees the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      mu_valid_q <= 1'b0;
      mu_id_q    <= '0;
      mu_force_q <= '0;
    end else begin
      mu_valid_q <= mu_rd;
      if (mu_rd) begin
        mu_id_q <= motion_update_rd_addr;
        if (mu_valid_q && (mu_id_q == motion_update_rd_addr)) begin
          mu_force_q <= '0;
        end else begin
          mu_force_q <= force_ram[motion_update_rd_addr];
        end
      end
    end
  end

  // Idle flag: running with nothing buffered or in flight next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      empty_q <= 1'b0;
    end else begin
      empty_q <= run && (cnt_d == '0) && !r_valid_d && !w_valid_d;
    end
  end

  assign all_force_input_buffer_empty = empty_q;
  assign force_to_MU                  = mu_force_q;
  assign force_id_to_MU               = mu_id_q;
  assign force_valid_to_MU            = mu_valid_q;
  assign in_buffer_full               = full_q;
  assign overflow                     = ovf_q;

endmodule
